// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the instruction-fetch front end:
// fetch FSM encoding, FIFO entry layout and PC arithmetic.
package fetch_queue_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] pc4;
        logic [INSTR_W-1:0] instr;
    } fifo_entry_t;

    // Next sequential fetch address; wraps modulo 2^32.
    function automatic logic [INSTR_W-1:0] pc_inc(input logic [INSTR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

    // Word-align an address by clearing the byte offset.
    function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] pc);
        return {pc[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bus bundle of the fetch front end: instruction-memory req/ack port,
// hazard/redirect controls from the pipeline and the IF/ID head outputs.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic               imem_req;
    logic [INSTR_W-1:0] imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               redirect;
    logic [INSTR_W-1:0] redirect_pc;
    logic               id_valid;
    logic [INSTR_W-1:0] id_pc4;
    logic [INSTR_W-1:0] id_order;

    modport master (
        output imem_req, imem_addr, id_valid, id_pc4, id_order,
        input  imem_ack, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_pc4, id_order,
        output imem_ack, imem_rdata, stall, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO of {pc4, instr} entries. Flush empties it and wins over
// a simultaneous push; the storage array itself is never reset.
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fifo_entry_t      din,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output fifo_entry_t      head
);
    localparam int PTR_W = $clog2(DEPTH);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & ~empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush returns to the empty state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one req/ack read at
// a time to instruction memory, and buffers returned words with their PC+4.
// A request is only issued when its response is guaranteed a FIFO slot, so the
// FIFO can never overflow regardless of memory latency.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                 DEPTH    = 4,
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t       state;
    logic [INSTR_W-1:0] fetch_pc;
    logic [INSTR_W-1:0] fetch_pc_inc;
    logic [INSTR_W-1:0] redirect_aligned;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               empty;
    logic               push;
    logic               pop;
    logic               space;
    fifo_entry_t        wr_entry;
    fifo_entry_t        head;

    assign redirect_aligned = align_pc(bus.redirect_pc);
    assign fetch_pc_inc     = pc_inc(fetch_pc);

    // Redirect dominates: it kills both the returning word and the ID pop.
    assign push     = (state == S_REQ) & bus.imem_ack & ~bus.redirect;
    assign pop      = ~empty & ~bus.stall & ~bus.redirect;
    assign wr_entry = '{pc4: fetch_pc_inc, instr: bus.imem_rdata};

    // Occupancy after this edge; the next request needs one free slot beyond it.
    always_comb begin
        count_next = count;
        if (bus.redirect) count_next = '0;
        else              count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    assign space = (count_next < CNT_W'(DEPTH));

    fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .din   (wr_entry),
        .count (count),
        .empty (empty),
        .head  (head)
    );

    assign bus.id_valid = ~empty;
    assign bus.id_pc4   = empty ? '0 : head.pc4;
    assign bus.id_order = empty ? NOP_INSTR : head.instr;

    // Fetch FSM with registered req/addr; S_DROP keeps the stale request
    // alive until memory acks it, since a request cannot be withdrawn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            fetch_pc      <= RESET_PC;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= RESET_PC;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.redirect) fetch_pc <= redirect_aligned;
                    if (space) begin
                        state         <= S_REQ;
                        bus.imem_req  <= 1'b1;
                        bus.imem_addr <= bus.redirect ? redirect_aligned : fetch_pc;
                    end
                end
                S_REQ: begin
                    if (bus.imem_ack) begin
                        if (bus.redirect) begin
                            fetch_pc      <= redirect_aligned;
                            bus.imem_addr <= redirect_aligned;
                        end else begin
                            fetch_pc      <= fetch_pc_inc;
                            bus.imem_addr <= fetch_pc_inc;
                            if (!space) begin
                                state        <= S_IDLE;
                                bus.imem_req <= 1'b0;
                            end
                        end
                    end else if (bus.redirect) begin
                        fetch_pc <= redirect_aligned;
                        state    <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (bus.imem_ack) begin
                        state         <= S_REQ;
                        fetch_pc      <= bus.redirect ? redirect_aligned : fetch_pc;
                        bus.imem_addr <= bus.redirect ? redirect_aligned : fetch_pc;
                    end else if (bus.redirect) begin
                        fetch_pc <= redirect_aligned;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    bus.imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scoreboard queue holds the {pc4, instr}
// words the front end must present, in order, at the IF/ID head.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst0 = 1'b0;
    logic rst1 = 1'b0;

    int n_err = 0;
    int n_checks = 0;

    logic [63:0] sb[$];
    logic [31:0] exp_pc = 32'h0;
    logic        in_drop = 1'b0;
    logic [31:0] drop_addr = 32'h0;

    logic [31:0] w_pc4 [3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    logic [31:0] w_ord [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    logic [31:0] w_adr [3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    fetch_queue_if bus0();
    fetch_queue_if bus1();

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0.master)
    );

    fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.master)
    );

    // Memory returns the requested address as the instruction word.
    assign bus0.imem_rdata = bus0.imem_addr;
    assign bus1.imem_rdata = bus1.imem_addr;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of dut0: drive inputs at negedge, check outputs, advance model.
    task automatic step(input logic ack, input logic stl, input logic rdr, input logic [31:0] rpc);
        logic req_now;
        logic acc;
        logic pop_now;
        bus0.imem_ack    = ack;
        bus0.stall       = stl;
        bus0.redirect    = rdr;
        bus0.redirect_pc = rpc;
        #1;
        chk("id_valid", 32'(bus0.id_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("id_pc4", bus0.id_pc4, sb[0][63:32]);
            chk("id_order", bus0.id_order, sb[0][31:0]);
        end else begin
            chk("id_pc4_empty", bus0.id_pc4, 32'h0);
            chk("id_order_nop", bus0.id_order, 32'h0);
        end
        req_now = bus0.imem_req;
        if (req_now) chk("imem_addr", bus0.imem_addr, in_drop ? drop_addr : exp_pc);
        acc     = ack && req_now && !rdr && !in_drop;
        pop_now = (sb.size() != 0) && !stl && !rdr;
        @(posedge clk);
        if (rdr) begin
            sb.delete();
            if (in_drop) begin
                if (ack) in_drop = 1'b0;
            end else if (req_now && !ack) begin
                in_drop   = 1'b1;
                drop_addr = exp_pc;
            end
            exp_pc = {rpc[31:2], 2'b00};
        end else begin
            if (in_drop && ack && req_now) in_drop = 1'b0;
            if (pop_now) void'(sb.pop_front());
            if (acc) begin
                sb.push_back({exp_pc + 32'd4, exp_pc});
                exp_pc = exp_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bus0.imem_ack = 1'b0; bus0.stall = 1'b0; bus0.redirect = 1'b0; bus0.redirect_pc = 32'h0;
        bus1.imem_ack = 1'b0; bus1.stall = 1'b0; bus1.redirect = 1'b0; bus1.redirect_pc = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_req", 32'(bus0.imem_req), 32'h0);
        chk("rst_addr", bus0.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus0.id_valid), 32'h0);
        chk("rst_pc4", bus0.id_pc4, 32'h0);
        chk("rst_order", bus0.id_order, 32'h0);
        rst0 = 1'b1;

        // 1: ack every cycle, one instruction per cycle
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t1_req", 32'(bus0.imem_req), 32'h1);

        // 2: stall with ack always on; FIFO fills and req drops
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("t2_req_dropped", 32'(bus0.imem_req), 32'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

        // 3: ack after three waiting cycles; request stays stable
        for (int i = 0; i < 3; i++) begin
            chk("t3_req_wait", 32'(bus0.imem_req), 32'h1);
            step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        chk("t3_req_ack", 32'(bus0.imem_req), 32'h1);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

        // 4: redirect while a request is pending without ack
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h100);
        chk("t4_drop_req", 32'(bus0.imem_req), 32'h1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t4_new_req", 32'(bus0.imem_req), 32'h1);
        chk("t4_new_addr", bus0.imem_addr, 32'h100);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // 5: redirect coinciding with ack, under stall
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h203);
        chk("t5_new_req", 32'(bus0.imem_req), 32'h1);
        chk("t5_new_addr", bus0.imem_addr, 32'h200);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // 6: PC wrap from a high reset PC, then async reset mid-request
        bus1.imem_ack = 1'b1;
        rst1 = 1'b1;
        #1;
        chk("t6_req0", 32'(bus1.imem_req), 32'h0);
        @(negedge clk); #1;
        chk("t6_req1", 32'(bus1.imem_req), 32'h1);
        chk("t6_addr1", bus1.imem_addr, 32'hFFFF_FFF8);
        chk("t6_valid1", 32'(bus1.id_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("t6_valid", 32'(bus1.id_valid), 32'h1);
            chk("t6_pc4", bus1.id_pc4, w_pc4[i]);
            chk("t6_order", bus1.id_order, w_ord[i]);
            chk("t6_addr", bus1.imem_addr, w_adr[i]);
        end
        #1;
        rst1 = 1'b0;
        #1;
        chk("t6_async_req", 32'(bus1.imem_req), 32'h0);
        chk("t6_async_valid", 32'(bus1.id_valid), 32'h0);
        chk("t6_async_addr", bus1.imem_addr, 32'hFFFF_FFF8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
